// File: rtl/dmem_sized_if.sv
// Load/store bus between the CPU data stage and dmem_sized.
// The master drives requests; the slave returns read data and status strobes.
interface dmem_sized_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  DM_CS;
  logic                  DM_R;
  logic                  DM_W;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           data_in;
  logic [31:0]           data_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  misalign_err;

  modport master (
    output DM_CS, DM_R, DM_W, size, sign_ext, addr, data_in,
    input  data_out, rd_valid, busy, misalign_err
  );

  modport slave (
    input  DM_CS, DM_R, DM_W, size, sign_ext, addr, data_in,
    output data_out, rd_valid, busy, misalign_err
  );
endinterface

// File: rtl/dmem_sized.sv
// Word-organised data RAM with byte/half/word little-endian accesses,
// registered sign/zero-extended reads and a post-reset zero-fill sequence.
module dmem_sized #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic         clk,
  input  logic         rst,
  dmem_sized_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] cnt, cnt_next;
  logic             busy, clr_we;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx, widx;
  logic [1:0]       lane;
  logic             legal, req, rd, wr;
  logic [3:0]       we;
  logic [31:0]      wdata, rword, rdata;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;

  logic [31:0]      data_out_q;
  logic             rd_valid_q, misalign_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state_next = READY;
      end
      default: ;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = 1'b1;
    clr_we = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      READY:   busy = 1'b0;
      default: ;
    endcase
  end

  assign idx  = bus.addr[IDX_W+1:2];
  assign lane = bus.addr[1:0];

  generate
    if (ADDR_WIDTH > int'(IDX_W) + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.addr[ADDR_WIDTH-1:IDX_W+2];
    end
  endgenerate

  always_comb begin
    case (bus.size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~lane[0];
      2'b10:   legal = (lane == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign req = bus.DM_CS & (bus.DM_R | bus.DM_W) & ~busy & ~rst;
  assign rd  = req & legal & bus.DM_R;
  assign wr  = req & legal & bus.DM_W;

  // Clear and CPU writes share one write port; they never overlap since wr needs ~busy.
  always_comb begin
    we    = '0;
    wdata = '0;
    widx  = idx;
    if (clr_we && !rst) begin
      we   = '1;
      widx = cnt;
    end else if (wr) begin
      case (bus.size)
        2'b00: begin
          we    = 4'b0001 << lane;
          wdata = {4{bus.data_in[7:0]}};
        end
        2'b01: begin
          we    = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{bus.data_in[15:0]}};
        end
        default: begin
          we    = '1;
          wdata = bus.data_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rword = mem[idx];
  assign rbyte = rword[lane*8 +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (bus.size)
      2'b00:   rdata = {{24{bus.sign_ext & rbyte[7]}}, rbyte};
      2'b01:   rdata = {{16{bus.sign_ext & rhalf[15]}}, rhalf};
      default: rdata = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rd_valid_q <= rd;
      misalign_q <= req & ~legal;
      if (rd) data_out_q <= rdata;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.busy         = busy;
endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised successor to the CPU data memory: word-organised synchronous RAM with byte, halfword and word accesses, sign/zero extension and little-endian byte lanes.
- Adds registered read with a valid strobe, misalignment detection, and a post-reset hardware clear sequence.
- Sits between the CPU load/store stage and on-chip block RAM, using the same DM_CS / DM_R / DM_W strobe scheme.

Parameters:
- ADDR_WIDTH, 32, width of the byte address input.
- DEPTH, 1024, number of 32-bit words; power of two, minimum 4.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- DM_CS  input  1  chip select; no access is performed when low.
- DM_R  input  1  read request (qualified by DM_CS).
- DM_W  input  1  write request (qualified by DM_CS).
- size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- sign_ext  input  1  reads: 1 = sign-extend, 0 = zero-extend; ignored for word accesses.
- addr  input  ADDR_WIDTH  byte address.
- data_in  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- data_out  output  32  registered read data, extended to 32 bits.
- rd_valid  output  1  one-cycle pulse: data_out was updated by a read.
- busy  output  1  high during reset and the clear sequence; accesses ignored while high.
- misalign_err  output  1  one-cycle pulse: the previous-cycle access was rejected.

Behaviour:
- Reset (rst = 1 at an edge):
  - data_out = 0, rd_valid = 0, misalign_err = 0, busy = 1.
  - Clear counter = 0; state = CLEAR.
  - Any in-flight read is dropped.
- State CLEAR:
  - Each cycle with rst = 0: write 0 to word[counter], then counter++.
  - After word DEPTH-1 is written, next state = READY and busy = 0.
  - Exactly DEPTH cycles from the first edge with rst low to busy low.
  - Any access request during CLEAR is ignored; no error pulse is raised.
- State READY: accesses are accepted. rst at any time returns to CLEAR with counter = 0.
- Address decode:
  - Word index = addr[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Lane = addr[1:0]; little-endian (lane 0 = bits [7:0]).
- Legality:
  - Byte: any alignment.
  - Half: requires addr[0] = 0.
  - Word: requires addr[1:0] = 00.
  - size = 11 is always illegal.
  - Illegal access with DM_CS & (DM_R | DM_W): no write, data_out unchanged, rd_valid = 0, misalign_err = 1 on the next cycle only.
- Write (DM_CS & DM_W & legal & READY):
  - Only the addressed lanes are modified at the edge.
  - Byte: data_in[7:0] goes to lane addr[1:0].
  - Half: data_in[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Read (DM_CS & DM_R & legal & READY):
  - Latency 1: at the next edge, data_out = the extracted field, shifted to bit 0 and extended per sign_ext; rd_valid = 1 for that cycle.
  - data_out holds its last value while rd_valid = 0.
- Read and write in the same cycle, same word: read-before-write; data_out returns the pre-write contents and the write takes effect.
- Back-to-back reads: one result per cycle, no bubbles.
- DM_CS = 0: DM_R, DM_W and addr are don't-care; no state change except the output strobes returning to 0.

Test Plan:
- Reset: rst high 2 cycles then low. Expect busy = 1 for exactly DEPTH cycles after release, with rst-time outputs at 0. Then a word read at addr 920 gives data_out = 0x00000000 with rd_valid pulsing 1 cycle later.
- Word write 0xDEADBEEF @ 12, then byte reads:
  - @12 sign_ext=0 → 0x000000EF.
  - @15 sign_ext=1 → 0xFFFFFFDE.
  - @15 sign_ext=0 → 0x000000DE.
- Halfword write 0x8001 @ 2 over word 0 = 0x11223344. Expect word read @0 = 0x80013344; half read @2 sign_ext=1 = 0xFFFF8001.
- Misalign: half write @1, word read @6, size = 11 read @0. Each gives a misalign_err pulse, rd_valid stays 0, data_out is unchanged, and memory is unchanged (verified by a word read).
- Same cycle: DM_R = DM_W = 1, word @0x20, data_in = 0xA5A5A5A5, old value 0x12345678. Expect data_out = 0x12345678; a subsequent read returns 0xA5A5A5A5.
- Wrap and reset mid-operation:
  - Write @ DEPTH*4 + 8 (0x1008 for DEPTH = 1024); a read @8 returns the same data.
  - Assert rst on the cycle of a pending read: rd_valid stays 0, busy rises, and after the clear sequence word @8 reads 0.
